// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder
//   SPI slave (mode 3, MSB first) that stands in for an ADXL345-style
//   accelerometer. It serves register reads/writes and X/Y/Z samples, and
//   raises the DATA_READY interrupt on INT1/INT2.
//
// Ports
//   clk, reset_n        system clock (>= 8x SCLK), async active-low reset
//   spi_csn/sclk/sdi    SPI inputs from the master, synchronized internally
//   spi_sdo, spi_sdo_oe 4-wire read data and its output enable
//   spi_sdi_out/_oe     3-wire read data and enable (optional feature)
//   sample_x/y/z        two's complement samples, loaded on sample_valid
//   int_out             [0]=INT1, [1]=INT2, registered
//
// Optional feature macro: GSENSOR_SPI_RESPONDER_3WIRE_EN
//   When defined, DATA_FORMAT[6]=1 moves read data onto spi_sdi_out/spi_sdi_oe.
//   When undefined, spi_sdi_out/spi_sdi_oe are tied to 0.
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID_VALUE = 8'hE5,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  output logic        spi_sdi_out,
  output logic        spi_sdi_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [1:0]  int_out
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;

  // Synchronizers; CSN and SCLK reset to their idle-high levels so that
  // leaving reset never looks like an edge.
  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync;
  logic csn_q, sclk_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_sync  <= '1;
      sclk_sync <= '1;
      sdi_sync  <= '0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      csn_q     <= csn_sync[SYNC_STAGES-1];
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic csn_s, sclk_s, sdi_s;
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  logic csn_fall, csn_rise, sclk_rise, sclk_fall;
  assign csn_fall  = csn_q & ~csn_s;
  assign csn_rise  = ~csn_q & csn_s;
  // SCLK activity only counts while the chip is selected.
  assign sclk_rise = ~sclk_q & sclk_s & ~csn_s;
  assign sclk_fall = sclk_q & ~sclk_s & ~csn_s;

  // Register file
  logic [7:0]       bw_rate, power_ctl, int_enable, int_map, data_format;
  logic             data_ready;
  logic [5:0][7:0]  live_q, shadow_q;   // index 0 = DATAX0

  // Transaction datapath
  logic [2:0] bit_cnt;    // SCLK rises within the current byte
  logic [2:0] tx_cnt;     // SCLK falls within the current read byte
  logic [6:0] rx_sr;
  logic [7:0] tx_sr, rd_data, rx_byte;
  logic       rw_q, mb_q, hit_q;
  logic [5:0] addr_q, tx_addr_q;
  logic       tx_in_data, wr_en, rd_oe, three_wire;

  assign rx_byte    = {rx_sr, sdi_s};
  assign tx_in_data = (tx_addr_q >= 6'h32) && (tx_addr_q <= 6'h37);
  assign wr_en      = (state_q == DATA) && !rw_q && sclk_rise && (bit_cnt == 3'd7);

  always_comb begin
    rd_data = 8'h00;
    case (addr_q)
      6'h00:   rd_data = DEVID_VALUE;
      6'h2C:   rd_data = bw_rate;
      6'h2D:   rd_data = power_ctl;
      6'h2E:   rd_data = int_enable;
      6'h2F:   rd_data = int_map;
      6'h30:   rd_data = {data_ready, 7'b0};
      6'h31:   rd_data = data_format;
      6'h32:   rd_data = shadow_q[0];
      6'h33:   rd_data = shadow_q[1];
      6'h34:   rd_data = shadow_q[2];
      6'h35:   rd_data = shadow_q[3];
      6'h36:   rd_data = shadow_q[4];
      6'h37:   rd_data = shadow_q[5];
      default: rd_data = 8'h00;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_oe   = 1'b0;
    case (state_q)
      IDLE: if (csn_fall) state_d = CMD;
      CMD: begin
        if (csn_rise)                              state_d = IDLE;
        else if (sclk_rise && (bit_cnt == 3'd7))   state_d = DATA;
      end
      DATA: begin
        // Gating with csn_s drops the enable in the cycle the rise is seen.
        rd_oe = rw_q & ~csn_s;
        if (csn_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      tx_cnt    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      rw_q      <= 1'b0;
      mb_q      <= 1'b0;
      hit_q     <= 1'b0;
      addr_q    <= '0;
      tx_addr_q <= '0;
      shadow_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt <= '0;
          tx_cnt  <= '0;
          tx_sr   <= '0;
          hit_q   <= 1'b0;
          // Reads in this transaction see one coherent snapshot.
          if (csn_fall) shadow_q <= live_q;
        end
        CMD: if (sclk_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rw_q   <= rx_byte[7];
            mb_q   <= rx_byte[6];
            addr_q <= rx_byte[5:0];
          end
        end
        DATA: begin
          if (sclk_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!rw_q && mb_q) addr_q <= addr_q + 6'd1;
              // A full data byte has been clocked out to the master.
              if (rw_q && tx_in_data) hit_q <= 1'b1;
            end
          end
          if (sclk_fall && rw_q) begin
            tx_cnt <= tx_cnt + 3'd1;
            if (tx_cnt == 3'd0) begin
              tx_sr     <= rd_data;
              tx_addr_q <= addr_q;
              if (mb_q) addr_q <= addr_q + 6'd1;
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registers, sample path and interrupts
  logic       dr_set, dr_clr;
  logic [7:0] int_src;
  assign dr_set  = sample_valid & power_ctl[3];
  assign dr_clr  = csn_rise & (state_q == DATA) & rw_q & hit_q;
  assign int_src = {data_ready, 7'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bw_rate     <= BW_RATE_RST;
      power_ctl   <= '0;
      int_enable  <= '0;
      int_map     <= '0;
      data_format <= '0;
      data_ready  <= 1'b0;
      live_q      <= '0;
      int_out     <= 2'b00;
    end else begin
      if (wr_en) begin
        case (addr_q)
          6'h2C:   bw_rate     <= rx_byte;
          6'h2D:   power_ctl   <= rx_byte;
          6'h2E:   int_enable  <= rx_byte;
          6'h2F:   int_map     <= rx_byte;
          6'h31:   data_format <= rx_byte;
          default: ;
        endcase
      end
      if (sample_valid) live_q <= {sample_z, sample_y, sample_x};
      // Set has priority over a coincident clear.
      if (dr_set)      data_ready <= 1'b1;
      else if (dr_clr) data_ready <= 1'b0;
      int_out <= {|(int_src & int_enable & int_map),
                  |(int_src & int_enable & ~int_map)};
    end
  end

`ifdef GSENSOR_SPI_RESPONDER_3WIRE_EN
  assign three_wire  = data_format[6];
  assign spi_sdi_oe  = rd_oe & three_wire;
  assign spi_sdi_out = spi_sdi_oe & tx_sr[7];
`else
  assign three_wire  = 1'b0;
  assign spi_sdi_oe  = 1'b0;
  assign spi_sdi_out = 1'b0;
`endif

  assign spi_sdo_oe = rd_oe & ~three_wire;
  assign spi_sdo    = spi_sdo_oe & tx_sr[7];

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Testbench for gsensor_spi_responder: a mode-3 SPI master drives register
// transactions; results are compared to a register-level model of the sensor.
module tb_gsensor_spi_responder;
  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_csn = 1'b1, spi_sclk = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe, spi_sdi_out, spi_sdi_oe;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  int_out;

  always #5 clk = ~clk;

  gsensor_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .spi_sdi_out(spi_sdi_out), .spi_sdi_oe(spi_sdi_oe),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .int_out(int_out)
  );

  int total = 0, bad = 0;

  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];
  logic [7:0] exp_buf [16];
  bit oe_cmd_hi, oe_dat_hi, oe_dat_lo;

  // ---------------- reference model ----------------
  logic [7:0] m_reg [64];
  logic [7:0] m_live [6];
  logic [7:0] m_shadow [6];
  logic       m_dr;

  function automatic bit m_writable(input int a);
    return a == 'h2C || a == 'h2D || a == 'h2E || a == 'h2F || a == 'h31;
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    if (a == 0) return 8'hE5;
    if (a == 'h30) return {m_dr, 7'b0};
    if (a >= 'h32 && a <= 'h37) return m_shadow[a - 'h32];
    if (m_writable(a)) return m_reg[a];
    return 8'h00;
  endfunction

  function automatic logic [1:0] m_int();
    logic [7:0] s;
    s = {m_dr, 7'b0};
    return {|(s & m_reg[6'h2E] & m_reg[6'h2F]), |(s & m_reg[6'h2E] & ~m_reg[6'h2F])};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[6'h2C] = 8'h0A;
    for (int i = 0; i < 6; i++) begin m_live[i] = 8'h00; m_shadow[i] = 8'h00; end
    m_dr = 1'b0;
  endtask

  // Applies a completed transaction (whole bytes only) to the model.
  task automatic m_txn(input logic [7:0] cmd, input int n);
    int a;
    bit hit;
    a = int'(cmd[5:0]);
    hit = 0;
    for (int b = 0; b < n; b++) begin
      if (cmd[7]) begin
        exp_buf[b] = m_rd(a);
        if (a >= 'h32 && a <= 'h37) hit = 1;
      end else if (m_writable(a)) begin
        m_reg[a] = tx_buf[b];
      end
      if (cmd[6]) a = (a + 1) % 64;
    end
    if (cmd[7] && hit) m_dr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  task automatic spi_bit(input logic b, output logic r, output logic oe);
    spi_sclk = 1'b0;
    spi_sdi  = b;
    repeat (HALF) @(negedge clk);
    r  = spi_sdo;
    oe = spi_sdo_oe;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Command byte, nbytes data bytes, then tail_bits of tx_buf[nbytes] (abort).
  task automatic spi_xfer(input logic [7:0] cmd, input int nbytes, input int tail_bits);
    logic r, oe;
    logic [7:0] acc, tb_byte;
    oe_cmd_hi = 0; oe_dat_hi = 0; oe_dat_lo = 0;
    spi_csn = 1'b0;
    for (int i = 0; i < 6; i++) m_shadow[i] = m_live[i];
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(cmd[i], r, oe);
      if (oe) oe_cmd_hi = 1;
    end
    for (int b = 0; b < nbytes; b++) begin
      acc = 8'h00;
      tb_byte = tx_buf[b];
      for (int i = 7; i >= 0; i--) begin
        spi_bit(tb_byte[i], r, oe);
        acc = {acc[6:0], r};
        if (oe) oe_dat_hi = 1; else oe_dat_lo = 1;
      end
      rx_buf[b] = acc;
    end
    tb_byte = tx_buf[nbytes];
    for (int i = 0; i < tail_bits; i++) spi_bit(tb_byte[7-i], r, oe);
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] v);
    tx_buf[0] = v;
    spi_xfer({2'b00, a}, 1, 0);
    m_txn({2'b00, a}, 1);
  endtask

  task automatic apply_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_live[0] = x[7:0]; m_live[1] = x[15:8];
    m_live[2] = y[7:0]; m_live[3] = y[15:8];
    m_live[4] = z[7:0]; m_live[5] = z[15:8];
    if (m_reg[6'h2D][3]) m_dr = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (4) @(negedge clk);
    total++;
    if ({spi_sdo, spi_sdo_oe, spi_sdi_out, spi_sdi_oe} !== 4'b0000) begin
      bad++; $display("FAIL reset_spi_outs: got %b want 0000", {spi_sdo, spi_sdo_oe, spi_sdi_out, spi_sdi_oe});
    end
    total++;
    if (int_out !== 2'b00) begin bad++; $display("FAIL reset_int: got %b want 00", int_out); end
    reset_n = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    for (int a = 'h2C; a <= 'h31; a++) begin
      spi_xfer({2'b10, 6'(a)}, 1, 0);
      m_txn({2'b10, 6'(a)}, 1);
      total++;
      if (rx_buf[0] !== exp_buf[0]) begin
        bad++; $display("FAIL reset_reg_%0h: got %h want %h", a, rx_buf[0], exp_buf[0]);
      end
    end
  endtask

  task automatic test_devid();
    spi_xfer(8'h80, 1, 0);
    m_txn(8'h80, 1);
    total++;
    if (rx_buf[0] !== exp_buf[0]) begin bad++; $display("FAIL devid: got %h want %h", rx_buf[0], exp_buf[0]); end
    total++;
    if ({oe_cmd_hi, oe_dat_lo} !== 2'b00) begin
      bad++; $display("FAIL devid_oe_window: cmd_hi=%b data_lo=%b want 0 0", oe_cmd_hi, oe_dat_lo);
    end
    total++;
    if ({spi_sdo_oe, spi_sdo, spi_sdi_oe} !== 3'b000) begin
      bad++; $display("FAIL devid_oe_after: got %b want 000", {spi_sdo_oe, spi_sdo, spi_sdi_oe});
    end
  endtask

  task automatic test_write_readback();
    do_write(6'h2D, 8'h08);
    total++;
    if (oe_dat_hi !== 1'b0) begin bad++; $display("FAIL write_oe: got %b want 0", oe_dat_hi); end
    spi_xfer(8'hAD, 1, 0);
    m_txn(8'hAD, 1);
    total++;
    if (rx_buf[0] !== exp_buf[0]) begin bad++; $display("FAIL power_ctl_rb: got %h want %h", rx_buf[0], exp_buf[0]); end
    do_write(6'h00, 8'h55);
    spi_xfer(8'h80, 1, 0);
    m_txn(8'h80, 1);
    total++;
    if (rx_buf[0] !== exp_buf[0]) begin bad++; $display("FAIL devid_ro: got %h want %h", rx_buf[0], exp_buf[0]); end
  endtask

  task automatic test_multibyte();
    logic [47:0] got;
    apply_sample(16'h0100, 16'hFF80, 16'h1234);
    spi_xfer(8'hF2, 6, 0);
    m_txn(8'hF2, 6);
    for (int b = 0; b < 6; b++) begin
      total++;
      if (rx_buf[b] !== exp_buf[b]) begin
        bad++; $display("FAIL mb_read_byte%0d: got %h want %h", b, rx_buf[b], exp_buf[b]);
      end
    end
    got = {rx_buf[5], rx_buf[4], rx_buf[3], rx_buf[2], rx_buf[1], rx_buf[0]};
    total++;
    if (got !== 48'h1234_FF80_0100) begin bad++; $display("FAIL mb_read_all: got %h want 1234ff800100", got); end
  endtask

  task automatic test_coherence_int();
    do_write(6'h2E, 8'h80);
    do_write(6'h2F, 8'h00);
    apply_sample(16'h0100, 16'hFF80, 16'h1234);
    repeat (4) @(negedge clk);
    total++;
    if (int_out !== m_int()) begin bad++; $display("FAIL int1_set: got %b want %b", int_out, m_int()); end
    fork
      spi_xfer(8'hF2, 6, 0);
      begin
        repeat (HALF + 16*HALF + 2*16*HALF + 4*HALF) @(negedge clk);
        apply_sample(16'h0200, 16'hFF80, 16'h1234);
      end
    join
    m_txn(8'hF2, 6);
    for (int b = 0; b < 6; b++) begin
      total++;
      if (rx_buf[b] !== exp_buf[b]) begin
        bad++; $display("FAIL coherent_byte%0d: got %h want %h", b, rx_buf[b], exp_buf[b]);
      end
    end
    total++;
    if (int_out !== m_int()) begin bad++; $display("FAIL int_clear: got %b want %b", int_out, m_int()); end
    spi_xfer(8'hF2, 2, 0);
    m_txn(8'hF2, 2);
    total++;
    if ({rx_buf[1], rx_buf[0]} !== {exp_buf[1], exp_buf[0]}) begin
      bad++; $display("FAIL new_sample: got %h%h want %h%h", rx_buf[1], rx_buf[0], exp_buf[1], exp_buf[0]);
    end
  endtask

  task automatic test_abort_wrap();
    tx_buf[0] = 8'h13;
    spi_xfer(8'h2E, 0, 5);
    spi_xfer(8'hAE, 1, 0);
    m_txn(8'hAE, 1);
    total++;
    if (rx_buf[0] !== exp_buf[0]) begin bad++; $display("FAIL abort_write: got %h want %h", rx_buf[0], exp_buf[0]); end
    spi_xfer(8'hFF, 2, 0);
    m_txn(8'hFF, 2);
    total++;
    if ({rx_buf[0], rx_buf[1]} !== {exp_buf[0], exp_buf[1]}) begin
      bad++; $display("FAIL addr_wrap: got %h %h want %h %h", rx_buf[0], rx_buf[1], exp_buf[0], exp_buf[1]);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [10];
    logic [5:0] a;
    logic [7:0] cmd;
    int n;
    pool = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h30, 6'h31, 6'h32, 6'h35, 6'h3F};
    for (int it = 0; it < 20; it++) begin
      a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 6'($urandom_range(0, 63));
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: apply_sample(16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          cmd = {1'b0, 1'($urandom_range(0, 1)), a};
          for (int b = 0; b < n; b++) tx_buf[b] = 8'($urandom);
          spi_xfer(cmd, n, 0);
          m_txn(cmd, n);
          total++;
          if (oe_dat_hi !== 1'b0) begin bad++; $display("FAIL rand_wr_oe: cmd %h got %b want 0", cmd, oe_dat_hi); end
        end
        default: begin
          cmd = {1'b1, 1'($urandom_range(0, 1)), a};
          spi_xfer(cmd, n, 0);
          m_txn(cmd, n);
          for (int b = 0; b < n; b++) begin
            total++;
            if (rx_buf[b] !== exp_buf[b]) begin
              bad++; $display("FAIL rand_rd: cmd %h byte %0d got %h want %h", cmd, b, rx_buf[b], exp_buf[b]);
            end
          end
        end
      endcase
      repeat (4) @(negedge clk);
      total++;
      if (int_out !== m_int()) begin bad++; $display("FAIL rand_int: iter %0d got %b want %b", it, int_out, m_int()); end
    end
  endtask

  task automatic test_reset_mid();
    logic r, oe;
    logic [7:0] cmd;
    do_write(6'h2C, 8'h0F);
    do_write(6'h2D, 8'h08);
    do_write(6'h2E, 8'h80);
    do_write(6'h2F, 8'h00);
    apply_sample(16'h0BAD, 16'h0001, 16'h0002);
    repeat (4) @(negedge clk);
    total++;
    if (int_out !== m_int()) begin bad++; $display("FAIL pre_reset_int: got %b want %b", int_out, m_int()); end
    cmd = 8'hAC;
    oe = 1'b0;
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r, oe);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r, oe);
    total++;
    if (oe !== 1'b1) begin bad++; $display("FAIL mid_read_oe: got %b want 1", oe); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({spi_sdo_oe, spi_sdo, int_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_outs: got %b want 0000", {spi_sdo_oe, spi_sdo, int_out});
    end
    spi_csn = 1'b1; spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    spi_xfer(8'hEC, 3, 0);
    m_txn(8'hEC, 3);
    for (int b = 0; b < 3; b++) begin
      total++;
      if (rx_buf[b] !== exp_buf[b]) begin
        bad++; $display("FAIL post_reset_byte%0d: got %h want %h", b, rx_buf[b], exp_buf[b]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin tx_buf[i] = 8'h00; rx_buf[i] = 8'h00; exp_buf[i] = 8'h00; end
    m_reset();
    test_reset();
    test_devid();
    test_write_readback();
    test_multibyte();
    test_coherence_int();
    test_abort_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
